shift_add_mult_onehot: RTL and testbench

- Sequential shift-and-add binary multiplier: a datapath (B, A, Q, C registers plus a bit counter P) driven by a 4-state ASM controller.
- Controller state is held one-hot, one flip-flop per state. An encoder converts it to a 2-bit binary state code for display and debug. This is the encode direction of the binary-state-plus-decoder controllers used elsewhere in the codebase.
- Used as a datapath/controller exercise block and as a unit in lab top levels.

---
 rtl/shift_add_mult_onehot.sv | 129 ++++++++++++
 tb/tb_shift_add_mult_onehot.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/shift_add_mult_onehot.sv
// ============================================================================
// Module   : shift_add_mult_onehot
// Brief    : Shift-and-add multiplier with a one-hot ASM controller and a
//            one-hot to binary state encoder for display/debug.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module shift_add_mult_onehot #(
    parameter int WIDTH = 4,
    parameter int PW    = $clog2(WIDTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic [2*WIDTH-1:0] product,
    output logic               busy,
    output logic               done,
    output logic [3:0]         state_onehot,
    output logic [1:0]         state_code,
    output logic               state_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_ADD   = 2'b01,
        S_SHIFT = 2'b10,
        S_DONE  = 2'b11
    } state_code_e;

    localparam int         IDX_IDLE    = 0;
    localparam int         IDX_ADD     = 1;
    localparam int         IDX_SHIFT   = 2;
    localparam int         IDX_DONE    = 3;
    localparam logic [3:0] ONEHOT_IDLE = 4'b0001;
    localparam logic [PW-1:0] P_LOAD   = PW'(WIDTH);

    logic [3:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             c_q, c_d;
    logic [PW-1:0]    p_q, p_d;

    logic             w_err;
    logic             w_p_zero;
    logic [WIDTH:0]   w_sum;
    state_code_e      w_code;

    // Exactly-one-bit test: clearing the lowest set bit must leave nothing.
    assign w_err    = (state_q == 4'd0) || ((state_q & (state_q - 4'd1)) != 4'd0);
    assign w_p_zero = (p_q == '0);
    assign w_sum    = {1'b0, a_q} + {1'b0, b_q};

    always_comb begin
        state_d = state_q;
        if (w_err) begin
            state_d = ONEHOT_IDLE;
        end else begin
            state_d[IDX_IDLE]  = (state_q[IDX_IDLE] & ~start) | state_q[IDX_DONE];
            state_d[IDX_ADD]   = (state_q[IDX_IDLE] & start)
                               | (state_q[IDX_SHIFT] & ~w_p_zero);
            state_d[IDX_SHIFT] = state_q[IDX_ADD];
            state_d[IDX_DONE]  = state_q[IDX_SHIFT] & w_p_zero;
        end
    end

    always_comb begin
        a_d = a_q;
        q_d = q_q;
        b_d = b_q;
        c_d = c_q;
        p_d = p_q;
        if (!w_err) begin
            if (state_q[IDX_IDLE] && start) begin
                b_d = multiplicand;
                q_d = multiplier;
                a_d = '0;
                c_d = 1'b0;
                p_d = P_LOAD;
            end
            if (state_q[IDX_ADD]) begin
                if (q_q[0]) begin
                    {c_d, a_d} = w_sum;
                end
                p_d = p_q - PW'(1);
            end
            if (state_q[IDX_SHIFT]) begin
                {c_d, a_d, q_d} = {1'b0, c_q, a_q, q_q[WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ONEHOT_IDLE;
            a_q     <= '0;
            q_q     <= '0;
            b_q     <= '0;
            c_q     <= 1'b0;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            q_q     <= q_d;
            b_q     <= b_d;
            c_q     <= c_d;
            p_q     <= p_d;
        end
    end

    // An illegal register reads back as idle so displays never show a bogus code.
    assign w_code = w_err ? S_IDLE
                          : state_code_e'({state_q[IDX_DONE] | state_q[IDX_SHIFT],
                                           state_q[IDX_DONE] | state_q[IDX_ADD]});

    assign product      = {a_q, q_q};
    assign busy         = (state_q != ONEHOT_IDLE);
    assign done         = (state_q == 4'b1000);
    assign state_onehot = state_q;
    assign state_code   = w_code;
    assign state_err    = w_err;

endmodule

`default_nettype wire

// File: tb/tb_shift_add_mult_onehot.sv
// ============================================================================
// Module   : tb_shift_add_mult_onehot
// Brief    : Self-checking bench for shift_add_mult_onehot against a plain
//            arithmetic product and the documented state sequence.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_shift_add_mult_onehot;

    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [W-1:0]   multiplicand;
    logic [W-1:0]   multiplier;
    logic [2*W-1:0] product;
    logic           busy;
    logic           done;
    logic [3:0]     state_onehot;
    logic [1:0]     state_code;
    logic           state_err;

    int n_checks = 0;
    int n_pass   = 0;

    shift_add_mult_onehot #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .product      (product),
        .busy         (busy),
        .done         (done),
        .state_onehot (state_onehot),
        .state_code   (state_code),
        .state_err    (state_err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    // Expected code e cycles after the accepting edge: ADD/SHIFT pairs, DONE, IDLE.
    function automatic int exp_code(input int e);
        if (e < 2*W)       return (e % 2 == 0) ? 1 : 2;
        else if (e == 2*W) return 3;
        else               return 0;
    endfunction

    task automatic run_mult(input int a, input int b, input string tag);
        int     done_at;
        int     busy_cycles;
        longint exp_prod;
        exp_prod = longint'(a) * longint'(b);
        @(negedge clk);
        start = 1'b1; multiplicand = W'(a); multiplier = W'(b);
        @(negedge clk);
        start = 1'b0;
        done_at = -1;
        busy_cycles = 0;
        for (int e = 0; e <= 2*W + 2; e++) begin
            if (busy) busy_cycles++;
            if (done && done_at < 0) begin
                done_at = e;
                check_val($sformatf("%s product %0d*%0d", tag, a, b), product, exp_prod);
            end
            check_val($sformatf("%s code e=%0d", tag, e), state_code, exp_code(e));
            if (e < 2*W + 2) @(negedge clk);
        end
        check_val($sformatf("%s done latency", tag), done_at, 2*W);
        check_val($sformatf("%s busy cycles", tag), busy_cycles, 2*W + 1);
        check_val($sformatf("%s product held", tag), product, exp_prod);
    endtask

    initial begin
        int d_at[$];
        int idle_between;
        int e;

        rst = 1'b1; start = 1'b0; multiplicand = '0; multiplier = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_val("reset onehot", state_onehot, 4'b0001);
            check_val("reset code", state_code, 0);
            check_val("reset product", product, 0);
            check_val("reset busy", busy, 0);
            check_val("reset done", done, 0);
            check_val("reset err", state_err, 0);
        end

        run_mult(13, 11, "basic");
        run_mult(15, 15, "carry");
        run_mult(0, 9, "zero_a");
        run_mult(9, 0, "zero_b");
        run_mult(1, 15, "one");
        for (int i = 0; i < 12; i++)
            run_mult(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), "rand");

        // Second start during SHIFT must be ignored.
        @(negedge clk);
        start = 1'b1; multiplicand = 4'd3; multiplier = 4'd5;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check_val("busy_start in shift", state_code, 2);
        start = 1'b1; multiplicand = 4'd7; multiplier = 4'd7;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 40 && !done; k++) @(negedge clk);
        check_val("busy_start done seen", done, 1);
        check_val("busy_start product", product, 15);
        repeat (2) @(negedge clk);
        check_val("busy_start not queued", busy, 0);
        check_val("busy_start product kept", product, 15);

        // Start held high: one idle cycle between consecutive DONE states.
        @(negedge clk);
        start = 1'b1; multiplicand = 4'd2; multiplier = 4'd3;
        idle_between = 0;
        e = 0;
        while (d_at.size() < 3 && e < 80) begin
            @(negedge clk);
            e++;
            if (done) begin
                d_at.push_back(e);
                check_val("b2b product", product, 6);
            end else if (d_at.size() == 1 && !busy) begin
                idle_between++;
            end
        end
        start = 1'b0;
        check_val("b2b done count", d_at.size(), 3);
        if (d_at.size() == 3) begin
            check_val("b2b gap 1", d_at[1] - d_at[0], 2*W + 2);
            check_val("b2b gap 2", d_at[2] - d_at[1], 2*W + 2);
        end
        check_val("b2b idle cycles", idle_between, 1);
        repeat (2*W + 4) @(negedge clk);
        check_val("b2b settled idle", busy, 0);

        // Asynchronous reset during the third ADD.
        @(negedge clk);
        start = 1'b1; multiplicand = 4'd13; multiplier = 4'd11;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check_val("midrst in add", state_code, 1);
        #2 rst = 1'b1;
        #1;
        check_val("midrst onehot", state_onehot, 4'b0001);
        check_val("midrst product", product, 0);
        check_val("midrst busy", busy, 0);
        check_val("midrst done", done, 0);
        @(negedge clk);
        rst = 1'b0;
        run_mult(6, 7, "after_rst");

        // Illegal one-hot values recover to idle with the datapath untouched.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (i == 0) force dut.state_q = 4'b0110;
            else        force dut.state_q = 4'b0000;
            #1;
            check_val($sformatf("illegal%0d err", i), state_err, 1);
            check_val($sformatf("illegal%0d code", i), state_code, 0);
            release dut.state_q;
            @(posedge clk);
            #1;
            check_val($sformatf("illegal%0d onehot", i), state_onehot, 4'b0001);
            check_val($sformatf("illegal%0d err clr", i), state_err, 0);
            check_val($sformatf("illegal%0d product", i), product, 42);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
